// File: rtl/inst_rom_loader_pkg.sv
// Shared types and helpers for the instruction ROM loader: FSM state codes
// and the byte mask used to zero-pad a partially filled final word.
package inst_rom_loader_pkg;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_RUN  = 2'd2
  } ld_state_e;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  // Keeps bytes 0..last_idx of a little-endian word and clears the rest.
  function automatic logic [WORD_W-1:0] word_mask(input logic [1:0] last_idx);
    return {{BYTE_W{last_idx == 2'd3}}, {BYTE_W{last_idx >= 2'd2}},
            {BYTE_W{last_idx >= 2'd1}}, {BYTE_W{1'b1}}};
  endfunction

endpackage

// File: rtl/inst_rom_loader_if.sv
// Program-load stream, CPU fetch port and CPU reset/status signals of the
// instruction ROM loader, bundled so the loader is the slave side.
interface inst_rom_loader_if #(
  parameter int ADDR_W = 10
);
  logic              ld_start;
  logic              ld_valid;
  logic [7:0]        ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_done;
  logic              ld_err;
  logic [ADDR_W:0]   ld_words;
  logic              cpu_rst;
  logic              rom_ce;
  logic [31:0]       rom_addr;
  logic [31:0]       rom_inst;

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last, rom_ce, rom_addr,
    output ld_ready, ld_done, ld_err, ld_words, cpu_rst, rom_inst
  );

  modport master (
    output ld_start, ld_valid, ld_data, ld_last, rom_ce, rom_addr,
    input  ld_ready, ld_done, ld_err, ld_words, cpu_rst, rom_inst
  );
endinterface

// File: rtl/inst_rom_loader_mem.sv
// Word-organised instruction store: synchronous write port for the loader,
// asynchronous read port so fetches resolve in the cycle the PC is presented.
module inst_rom_loader_mem #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM and keeps its program across rst_n.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction ROM loader: assembles a byte-serial program into 32-bit words,
// holds the CPU in reset until the load completes, then serves fetches.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inst_rom_loader_if.slave      bus
);
  localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};

  ld_state_e       state_q, state_d;
  logic [ADDR_W:0] words_q, words_d;
  logic [1:0]      idx_q, idx_d;
  logic [31:0]     wbuf_q, wbuf_d;
  logic            err_q, err_d;
  logic            cpu_rst_q, done_q;

  logic            mem_we;
  logic [31:0]     mem_wdata, asm_word, rdata;
  logic            in_range;
  logic            unused_addr_bits;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    words_d   = words_q;
    idx_d     = idx_q;
    wbuf_d    = wbuf_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    asm_word  = wbuf_q;

    if (bus.ld_start) begin
      state_d = LD_LOAD;
      words_d = '0;
      idx_d   = '0;
      wbuf_d  = '0;
      err_d   = 1'b0;
    end else if (state_q == LD_LOAD && bus.ld_valid) begin
      asm_word[8*idx_q +: 8] = bus.ld_data;
      wbuf_d = asm_word;
      idx_d  = idx_q + 2'd1;
      if (idx_q == 2'd3 || bus.ld_last) begin
        // A full array drops the word and latches the error; the count saturates.
        if (words_q == DEPTH_W) begin
          err_d = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_wdata = asm_word & word_mask(idx_q);
          words_d   = words_q + 1'b1;
        end
      end
      if (bus.ld_last) state_d = LD_RUN;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LD_IDLE;
      words_q   <= '0;
      idx_q     <= '0;
      wbuf_q    <= '0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      words_q   <= words_d;
      idx_q     <= idx_d;
      wbuf_q    <= wbuf_d;
      err_q     <= err_d;
      cpu_rst_q <= (state_d != LD_RUN);
      done_q    <= (state_d == LD_RUN);
    end
  end

  inst_rom_loader_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (words_q[ADDR_W-1:0]),
    .wdata_i (mem_wdata),
    .raddr_i (bus.rom_addr[ADDR_W+1:2]),
    .rdata_o (rdata)
  );

  // Byte offset within the word is irrelevant to word-aligned fetches.
  assign unused_addr_bits = ^bus.rom_addr[1:0];
  assign in_range         = (bus.rom_addr[31:ADDR_W+2] == '0);

  assign bus.rom_inst = (state_q == LD_RUN && bus.rom_ce && in_range) ? rdata : '0;
  assign bus.ld_ready = (state_q == LD_LOAD) && !bus.ld_start;
  assign bus.ld_done  = done_q;
  assign bus.ld_err   = err_q;
  assign bus.ld_words = words_q;
  assign bus.cpu_rst  = cpu_rst_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: a word-level model of the load/run
// behaviour is checked against the DUT every cycle, plus literal spot checks.
module tb_inst_rom_loader;
  import inst_rom_loader_pkg::*;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  inst_rom_loader_if #(.ADDR_W(ADDR_W)) bus ();

  inst_rom_loader #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: program bytes collected per word, words appended to an image.
  bit          m_loading = 0, m_run = 0, m_err = 0;
  int          m_words = 0, m_nbytes = 0;
  logic [7:0]  m_bytes [4];
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [31:0] m_word;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading = 0; m_run = 0; m_err = 0; m_words = 0; m_nbytes = 0;
    end else if (bus.ld_start) begin
      m_loading = 1; m_run = 0; m_err = 0; m_words = 0; m_nbytes = 0;
      foreach (m_known[i]) m_known[i] = 0;
    end else if (m_loading && bus.ld_valid) begin
      m_bytes[m_nbytes] = bus.ld_data;
      m_nbytes++;
      if (m_nbytes == 4 || bus.ld_last) begin
        m_word = 0;
        for (int b = 0; b < m_nbytes; b++) m_word = m_word | (32'(m_bytes[b]) << (8 * b));
        if (m_words < DEPTH) begin
          m_mem[m_words] = m_word; m_known[m_words] = 1; m_words++;
        end else m_err = 1;
        m_nbytes = 0;
      end
      if (bus.ld_last) begin m_loading = 0; m_run = 1; end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] widx;
      check("cpu_rst",  32'(bus.cpu_rst),  32'(!m_run));
      check("ld_done",  32'(bus.ld_done),  32'(m_run));
      check("ld_err",   32'(bus.ld_err),   32'(m_err));
      check("ld_words", 32'(bus.ld_words), 32'(m_words));
      check("ld_ready", 32'(bus.ld_ready), 32'(m_loading && !bus.ld_start));
      widx = bus.rom_addr / 4;
      if (!(m_run && bus.rom_ce) || widx >= DEPTH) check("rom_inst_zero", bus.rom_inst, 32'h0);
      else if (m_known[widx]) check("rom_inst", bus.rom_inst, m_mem[widx]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    bus.ld_valid = 1'b1; bus.ld_data = b; bus.ld_last = last;
    tick();
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
  endtask

  initial begin
    bus.ld_start = 0; bus.ld_valid = 0; bus.ld_data = 0; bus.ld_last = 0;
    bus.rom_ce = 0; bus.rom_addr = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // 1: out of reset with no load
    bus.rom_ce = 1; bus.rom_addr = 0;
    tick();
    check("t1_cpu_rst",  32'(bus.cpu_rst),  32'd1);
    check("t1_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("t1_ld_done",  32'(bus.ld_done),  32'd0);
    check("t1_rom_inst", bus.rom_inst,      32'h0);

    // 2: single full word
    start_load();
    send(8'h13, 0); send(8'h05, 0); send(8'h10, 0); send(8'h00, 1);
    #1;
    check("t2_cpu_rst",  32'(bus.cpu_rst),  32'd0);
    check("t2_ld_words", 32'(bus.ld_words), 32'd1);
    check("t2_rom_inst", bus.rom_inst,      32'h00100513);
    tick();

    // 3: partial final word is zero-padded
    start_load();
    for (int i = 1; i <= 6; i++) send(8'(i), i == 6);
    check("t3_ld_words", 32'(bus.ld_words), 32'd2);
    bus.rom_addr = 4;  #1 check("t3_addr4", bus.rom_inst, 32'h00000605);
    bus.rom_addr = 6;  #1 check("t3_addr6", bus.rom_inst, 32'h00000605);
    bus.rom_addr = 0;  #1 check("t3_addr0", bus.rom_inst, 32'h04030201);
    bus.rom_addr = 16; #1 check("t3_out_of_range", bus.rom_inst, 32'h0);
    bus.rom_addr = 0;
    tick();

    // 4: 17 words into a 4-word array
    start_load();
    for (int w = 0; w < 17; w++)
      for (int b = 0; b < 4; b++) send(8'(8'h10 + w * 4 + b), (w == 16) && (b == 3));
    #1;
    check("t4_ld_err",   32'(bus.ld_err),   32'd1);
    check("t4_ld_words", 32'(bus.ld_words), 32'd4);
    check("t4_word0",    bus.rom_inst,      32'h13121110);
    check("t4_ld_done",  32'(bus.ld_done),  32'd1);
    tick();

    // 5: restart mid-load drops the coincident byte; restart from RUN
    start_load();
    send(8'hAA, 0); send(8'hBB, 0);
    bus.ld_start = 1; bus.ld_valid = 1; bus.ld_data = 8'hCC;
    tick();
    bus.ld_start = 0; bus.ld_valid = 0;
    check("t5_ld_words", 32'(bus.ld_words), 32'd0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
    #1 check("t5_word0", bus.rom_inst, 32'h44332211);
    start_load();
    check("t5_run_restart_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("t5_run_restart_done",    32'(bus.ld_done), 32'd0);
    tick();

    // 6: reset mid-word, then a clean reload
    start_load();
    send(8'hDE, 0); send(8'hAD, 0);
    #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("t6_cpu_rst",  32'(bus.cpu_rst),  32'd1);
    check("t6_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("t6_ld_words", 32'(bus.ld_words), 32'd0);
    tick();
    start_load();
    send(8'h78, 0); send(8'h56, 0); send(8'h34, 0); send(8'h12, 1);
    #1 check("t6_word0", bus.rom_inst, 32'h12345678);
    bus.rom_ce = 0;
    #1 check("t6_rom_ce_off", bus.rom_inst, 32'h0);
    repeat (3) tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
